// File: rtl/mbist_march_ctrl_if.sv
// mbist_march_ctrl_if
//   RAM-side bus between the March C- BIST controller and single_port_ram.
//   master : controller side (drives address, write data, write enable)
//   slave  : RAM side (returns read data)
// Signals:
//   ram_addr    [$clog2(WCOUNT)] word address
//   ram_datain  [WLENGTH]        write data
//   ram_we                       write enable
//   ram_dataout [WLENGTH]        read data, READ_LAT cycles after address
interface mbist_march_ctrl_if #(
  parameter int unsigned WCOUNT  = 256,
  parameter int unsigned WLENGTH = 4
);
  localparam int unsigned AW = $clog2(WCOUNT);

  logic [AW-1:0]      ram_addr;
  logic [WLENGTH-1:0] ram_datain;
  logic               ram_we;
  logic [WLENGTH-1:0] ram_dataout;

  modport master (
    output ram_addr,
    output ram_datain,
    output ram_we,
    input  ram_dataout
  );

  modport slave (
    input  ram_addr,
    input  ram_datain,
    input  ram_we,
    output ram_dataout
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
//   March C- memory BIST controller for single_port_ram. Issues one RAM
//   operation per clock (10*WCOUNT ops), checks read data through a
//   READ_LAT-deep expected-data pipeline, then reports pass/fail.
//   Elements: M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 down(r0,w1)
//             M4 down(r1,w0) M5 up(r0)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        level; sampled only in IDLE or DONE
//   ram          RAM bus (master modport): addr/datain/we out, dataout in
//   busy         first op cycle through end of drain
//   done, pass   test finished / finished with no mismatch
//   fail         sticky mismatch flag, cleared on start
//   err_addr, err_exp, err_act, err_elem   first-failure diagnostics
//   err_cnt      mismatch count, saturating at 255 (MBIST_DIAG_EN only)
// Build option:
//   MBIST_DIAG_EN  defined: diagnostics live and err_cnt present;
//                  undefined: diagnostics tied to 0, err_cnt absent.
module mbist_march_ctrl #(
  parameter int unsigned WCOUNT   = 256,
  parameter int unsigned WLENGTH  = 4,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  mbist_march_ctrl_if.master        ram,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [$clog2(WCOUNT)-1:0] err_addr,
  output logic [WLENGTH-1:0]        err_exp,
  output logic [WLENGTH-1:0]        err_act,
  output logic [2:0]                err_elem
`ifdef MBIST_DIAG_EN
  ,
  output logic [7:0]                err_cnt
`endif
);

  localparam int unsigned AW   = $clog2(WCOUNT);
  localparam int unsigned LAST = READ_LAT - 1;
  localparam int unsigned DCW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [AW-1:0] ADDR_MAX = AW'(WCOUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     elem_q, elem_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           ph_q, ph_d;       // 0: first op of element pair, 1: write
  logic [DCW-1:0] drain_q, drain_d;

  logic               op_rd;
  logic               op_wr;
  logic               clear;
  logic               single;
  logic               down;
  logic               at_end;
  logic [WLENGTH-1:0] wr_data;
  logic [WLENGTH-1:0] rd_exp;
  logic               mismatch;

  logic               pipe_v   [READ_LAT];
  logic [WLENGTH-1:0] pipe_exp [READ_LAT];

  // Odd elements (M1, M3, M5) read zeros and write ones; even ones the
  // reverse. M0 is even and writes zeros.
  assign wr_data = {WLENGTH{elem_q[0]}};
  assign rd_exp  = ~wr_data;

  assign single = (elem_q == 3'd0) || (elem_q == 3'd5);
  assign down   = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign at_end = down ? (addr_q == '0) : (addr_q == ADDR_MAX);

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    drain_d = drain_q;
    op_rd   = 1'b0;
    op_wr   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          elem_d  = '0;
          addr_d  = '0;
          ph_d    = 1'b0;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        if (elem_q == 3'd0)      op_wr = 1'b1;
        else if (single || !ph_q) op_rd = 1'b1;
        else                      op_wr = 1'b1;

        if (single || ph_q) begin
          ph_d = 1'b0;
          if (at_end) begin
            if (elem_q == 3'd5) begin
              state_d = S_DRAIN;
            end else begin
              elem_d = elem_q + 3'd1;
              // M3 and M4 start from the top address.
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
            end
          end else begin
            addr_d = down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
          end
        end else begin
          ph_d = 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DCW'(1);
        if (drain_q == DCW'(READ_LAT - 1)) begin
          state_d = S_DONE;
          drain_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      drain_q <= drain_d;
    end
  end

  assign ram.ram_addr   = addr_q;
  assign ram.ram_we     = op_wr;
  assign ram.ram_datain = op_wr ? wr_data : '0;

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign pass = done && !fail;

  assign mismatch = pipe_v[LAST] && (ram.ram_dataout != pipe_exp[LAST]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_exp[i] <= '0;
      end
      fail <= 1'b0;
    end else begin
      pipe_v[0]   <= op_rd;
      pipe_exp[0] <= rd_exp;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end
      if (clear)         fail <= 1'b0;
      else if (mismatch) fail <= 1'b1;
    end
  end

`ifdef MBIST_DIAG_EN
  logic [AW-1:0] pipe_addr [READ_LAT];
  logic [2:0]    pipe_elem [READ_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_addr[i] <= '0;
        pipe_elem[i] <= '0;
      end
      err_addr <= '0;
      err_exp  <= '0;
      err_act  <= '0;
      err_elem <= '0;
      err_cnt  <= '0;
    end else begin
      pipe_addr[0] <= addr_q;
      pipe_elem[0] <= elem_q;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_elem[i] <= pipe_elem[i-1];
      end
      if (clear) begin
        err_addr <= '0;
        err_exp  <= '0;
        err_act  <= '0;
        err_elem <= '0;
        err_cnt  <= '0;
      end else if (mismatch) begin
        // First failure wins: capture only while fail is still clear.
        if (!fail) begin
          err_addr <= pipe_addr[LAST];
          err_exp  <= pipe_exp[LAST];
          err_act  <= ram.ram_dataout;
          err_elem <= pipe_elem[LAST];
        end
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`else
  assign err_addr = '0;
  assign err_exp  = '0;
  assign err_act  = '0;
  assign err_elem = '0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl
//   Self-checking bench for mbist_march_ctrl with a behavioural RAM
//   (two-register read path) and selectable injected faults.
module tb_mbist_march_ctrl;

  localparam int unsigned WCOUNT   = 256;
  localparam int unsigned WLENGTH  = 4;
  localparam int unsigned READ_LAT = 2;
  localparam int NOPS  = 10 * WCOUNT;
  localparam int NSAMP = NOPS + READ_LAT + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, pass, fail;
  logic [7:0] err_addr;
  logic [3:0] err_exp, err_act;
  logic [2:0] err_elem;
`ifdef MBIST_DIAG_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.WCOUNT(WCOUNT), .WLENGTH(WLENGTH)) bus ();

  mbist_march_ctrl #(
    .WCOUNT   (WCOUNT),
    .WLENGTH  (WLENGTH),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ram      (bus),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .err_addr (err_addr),
    .err_exp  (err_exp),
    .err_act  (err_act),
    .err_elem (err_elem)
`ifdef MBIST_DIAG_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  // RAM model: address registered, then data registered with its address.
  logic [3:0] mem [WCOUNT];
  logic [7:0] raddr_q, oaddr_q;
  logic [3:0] q, dout;
  int         fault_sel;   // 0 none, 1 bit2 forced high at 0x5A, 2 bit0 stuck low at 0x00

  always_ff @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_datain;
    raddr_q <= bus.ram_addr;
    q       <= mem[raddr_q];
    oaddr_q <= raddr_q;
  end

  always_comb begin
    dout = q;
    if (fault_sel == 1 && oaddr_q == 8'h5A) dout[2] = 1'b1;
    if (fault_sel == 2 && oaddr_q == 8'h00) dout[0] = 1'b0;
  end
  assign bus.ram_dataout = dout;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected op at op cycle c (c = 0 is the cycle after start is sampled).
  function automatic void exp_op(input int c, output logic [7:0] a,
                                 output logic we, output logic [3:0] d);
    int e, k;
    a = 8'h00; we = 1'b0; d = 4'h0;
    if (c < 256) begin
      a = 8'(c); we = 1'b1;
    end else if (c < 2304) begin
      e  = (c - 256) / 512 + 1;
      k  = (c - 256) % 512;
      we = k[0];
      a  = (e >= 3) ? 8'(255 - k / 2) : 8'(k / 2);
      d  = (we && (e == 1 || e == 3)) ? 4'hF : 4'h0;
    end else begin
      a = 8'(c - 2304);
    end
  endfunction

  logic [7:0] s_addr [NSAMP];
  logic       s_we   [NSAMP];
  logic [3:0] s_din  [NSAMP];
  logic       s_busy [NSAMP];
  logic       s_done [NSAMP];
  logic       s_fail [NSAMP];

  // Follows one run from the cycle after start is sampled to the first DONE
  // cycle, checking every op cycle against the March C- order.
  task automatic track_run(input string tag, input bit hold);
    logic [7:0] a;
    logic       we;
    logic [3:0] d;
    int         seq_err = 0;
    for (int c = 0; c < NSAMP; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) start = 1'b0;
      s_addr[c] = bus.ram_addr;
      s_we[c]   = bus.ram_we;
      s_din[c]  = bus.ram_datain;
      s_busy[c] = busy;
      s_done[c] = done;
      s_fail[c] = fail;
      if (c < NOPS) begin
        exp_op(c, a, we, d);
        if (bus.ram_addr !== a || bus.ram_we !== we || bus.ram_datain !== d ||
            busy !== 1'b1 || done !== 1'b0)
          seq_err++;
      end else if (c < NOPS + READ_LAT) begin
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 8'hFF || busy !== 1'b1 || done !== 1'b0)
          seq_err++;
      end
    end
    check({tag, "_op_seq_errors"}, 32'(seq_err), 32'd0);
    check({tag, "_done_edge"}, 32'({s_done[NOPS+READ_LAT-1], s_done[NOPS+READ_LAT]}), 32'b01);
    check({tag, "_busy_end"}, 32'({s_busy[NOPS+READ_LAT-1], s_busy[NOPS+READ_LAT]}), 32'b10);
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic       we;
    logic [3:0] din;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs [19];

  initial begin
    vecs[0]  = '{0,    8'h00, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[1]  = '{255,  8'hFF, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[2]  = '{256,  8'h00, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[3]  = '{257,  8'h00, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[4]  = '{258,  8'h01, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[5]  = '{767,  8'hFF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[6]  = '{768,  8'h00, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[7]  = '{769,  8'h00, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[8]  = '{1280, 8'hFF, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[9]  = '{1281, 8'hFF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[10] = '{1282, 8'hFE, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[11] = '{1791, 8'h00, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[12] = '{1792, 8'hFF, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[13] = '{1793, 8'hFF, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[14] = '{2303, 8'h00, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[15] = '{2304, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[16] = '{2559, 8'hFF, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[17] = '{2560, 8'hFF, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[18] = '{2561, 8'hFF, 1'b0, 4'h0, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; fault_sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_bus", 32'({bus.ram_addr, bus.ram_we, bus.ram_datain}), 32'd0);
    check("reset_status", 32'({busy, done, pass, fail}), 32'd0);
    check("reset_diag", 32'({err_addr, err_exp, err_act, err_elem}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_status", 32'({busy, done, pass, fail, bus.ram_we}), 32'd0);

    // Run A: fault-free, checkpoints compared from the vector table.
    start = 1'b1;
    track_run("runA", 1'b0);
    check("runA_pass_fail", 32'({pass, fail}), 32'b10);
    for (int i = 0; i < 19; i++)
      check($sformatf("vec%0d_c%0d", i, vecs[i].cyc),
            32'({s_addr[vecs[i].cyc], s_we[vecs[i].cyc], s_din[vecs[i].cyc],
                 s_busy[vecs[i].cyc], s_done[vecs[i].cyc]}),
            32'({vecs[i].addr, vecs[i].we, vecs[i].din, vecs[i].busy, vecs[i].done}));
    repeat (4) @(negedge clk);
    check("done_hold", 32'({done, busy, pass}), 32'b101);

    // Run B: bit 2 reads high at 0x5A; first hit is the M1 r0 of 0x5A.
    fault_sel = 1; start = 1'b1;
    track_run("runB", 1'b0);
    check("runB_pass_fail", 32'({pass, fail}), 32'b01);
`ifdef MBIST_DIAG_EN
    check("runB_diag", 32'({err_addr, err_elem, err_exp, err_act}), 32'({8'h5A, 3'd1, 4'h0, 4'h4}));
    // 0x5A is read expecting zeros in M1, M3 and M5.
    check("runB_err_cnt", 32'(err_cnt), 32'd3);
`else
    check("runB_diag_tied", 32'({err_addr, err_elem, err_exp, err_act}), 32'd0);
`endif

    // Run C: bit 0 stuck low at 0x00, start held high through the run.
    fault_sel = 2; start = 1'b1;
    track_run("runC", 1'b1);
    check("runC_pass_fail", 32'({pass, fail}), 32'b01);
`ifdef MBIST_DIAG_EN
    check("runC_diag", 32'({err_addr, err_elem, err_exp, err_act}), 32'({8'h00, 3'd2, 4'hF, 4'hE}));
    check("runC_err_cnt", 32'(err_cnt), 32'd2);
`else
    check("runC_diag_tied", 32'({err_addr, err_elem, err_exp, err_act}), 32'd0);
`endif

    // Run D: held start restarts straight out of DONE; fault removed.
    fault_sel = 0;
    track_run("runD", 1'b0);
    check("runD_fail_cleared", 32'(s_fail[0]), 32'd0);
    check("runD_pass_fail", 32'({pass, fail}), 32'b10);

    // Run E: reset at op cycle 1000 of a failing run, then a clean run.
    fault_sel = 1; start = 1'b1;
    for (int c = 0; c <= 1000; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
    end
    check("abort_pre_fail", 32'({busy, fail}), 32'b11);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({bus.ram_addr, bus.ram_we, bus.ram_datain, busy, done, pass, fail}), 32'd0);
    check("abort_diag", 32'({err_addr, err_exp, err_act, err_elem}), 32'd0);
    @(posedge clk);
    #1;
    check("abort_held", 32'({bus.ram_we, busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; fault_sel = 0; start = 1'b1;
    track_run("runF", 1'b0);
    check("runF_pass_fail", 32'({pass, fail}), 32'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
